// File: rtl/ct_stream_out_pkg.sv
// Shared definitions for the ciphertext egress engine.
// Provides default geometry for the ROLLO encrypt datapath, a minimum-one clog2
// helper for sizing address/counter fields, and the FSM state encoding.
package ct_stream_out_pkg;

    localparam int unsigned M_DEF     = 8;
    localparam int unsigned N_DEF     = 5;
    localparam int unsigned DIGIT_DEF = 2;
    localparam int unsigned NCH_DEF   = 2;
    localparam int unsigned W_OUT_DEF = 32;

    // Width needed to index v items; never returns 0 so single-entry fields stay legal.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/ct_stream_out_if.sv
// Valid/ready output stream carrying the packed ciphertext bitstream.
//   dout       : W-bit word, LSB-first bitstream
//   dout_valid : dout holds a word
//   dout_ready : sink accepts when dout_valid && dout_ready
//   dout_last  : final word of the transfer, qualified by dout_valid
interface ct_stream_if #(
    parameter int unsigned W = 32
);
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         dout_last;

    modport master (
        output dout,
        output dout_valid,
        output dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  dout_last,
        output dout_ready
    );
endinterface

// File: rtl/ct_bit_packer.sv
// Bit accumulation buffer for the egress engine.
// Appends the low append_len bits of append_bits above the current fill, and on
// shift_en discards the low OUT_W bits. When both are asserted the shift is applied
// first. Bits above fill are always zero, so the final word comes out zero-padded.
//   clk, rst_b  : clock, synchronous active-high reset
//   append_en   : append append_bits[append_len-1:0] at position fill
//   append_bits : source word
//   append_len  : number of valid source bits
//   shift_en    : drop OUT_W bits from the bottom (fill saturates at 0)
//   buf_lo      : low OUT_W bits of the buffer
//   fill        : number of valid bits held
module ct_bit_packer #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 8,
    localparam int unsigned BUF_W  = IN_W + OUT_W - 1,
    localparam int unsigned FILL_W = $clog2(BUF_W + 1)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              append_en,
    input  logic [IN_W-1:0]   append_bits,
    input  logic [FILL_W-1:0] append_len,
    input  logic              shift_en,
    output logic [OUT_W-1:0]  buf_lo,
    output logic [FILL_W-1:0] fill
);

    localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);

    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [BUF_W-1:0]  shifted;
    logic [FILL_W-1:0] fill_s;
    logic [IN_W-1:0]   masked;
    logic [BUF_W-1:0]  ext;

    always_comb begin
        shifted = buf_q;
        fill_s  = fill_q;
        if (shift_en) begin
            shifted = buf_q >> OUT_W;
            fill_s  = (fill_q > OUT_W_F) ? fill_q - OUT_W_F : '0;
        end

        // Drop bits beyond append_len (e.g. unused coefficients of the last word).
        masked = '0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            masked[i] = append_bits[i] & (FILL_W'(i) < append_len);
        end
        ext            = '0;
        ext[IN_W-1:0]  = masked;

        buf_d  = shifted;
        fill_d = fill_s;
        if (append_en) begin
            buf_d  = shifted | (ext << fill_s);
            fill_d = fill_s + append_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
        end
    end

    assign buf_lo = buf_q[OUT_W-1:0];
    assign fill   = fill_q;

endmodule

// File: rtl/ct_stream_out.sv
// Ciphertext egress engine.
// Reads NCH single-port ciphertext memories (1-cycle read latency), packs the valid
// coefficient bits of each word into a contiguous LSB-first bitstream and emits it
// as W_OUT-bit words. mode=0 concatenates channels, mode=1 XORs them word-wise.
//   clk, rst_b : clock, synchronous active-high reset
//   start      : one-cycle pulse, accepted only when idle
//   mode       : 0 = concat, 1 = XOR; sampled on accepted start
//   mem_addr   : shared read address (0 when idle)
//   mem_rw     : always 0 (read only)
//   mem_din    : read data, channel c at [c*M*DIGIT +: M*DIGIT]
//   out_if     : output stream (dout/dout_valid/dout_ready/dout_last)
//   busy       : transfer in progress
//   done       : one-cycle pulse after the final handshake
module ct_stream_out
    import ct_stream_out_pkg::*;
#(
    parameter int unsigned M      = M_DEF,
    parameter int unsigned N      = N_DEF,
    parameter int unsigned DIGIT  = DIGIT_DEF,
    parameter int unsigned NCH    = NCH_DEF,
    parameter int unsigned W_OUT  = W_OUT_DEF,
    parameter int unsigned DEPTH  = (N / DIGIT) + ((N % DIGIT) != 0 ? 1 : 0),
    parameter int unsigned ADDR_W = clog2_min1(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      start,
    input  logic                      mode,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_rw,
    input  logic [NCH*M*DIGIT-1:0]    mem_din,
    ct_stream_if.master               out_if,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned WORD_W    = M * DIGIT;
    localparam int unsigned BUF_W     = WORD_W + W_OUT - 1;
    localparam int unsigned FILL_W    = $clog2(BUF_W + 1);
    localparam int unsigned CHAN_W    = clog2_min1(NCH);
    localparam int unsigned LAST_COEF = N - (DEPTH - 1) * DIGIT;

    localparam logic [FILL_W-1:0] FULL_LEN  = FILL_W'(WORD_W);
    localparam logic [FILL_W-1:0] LAST_LEN  = FILL_W'(LAST_COEF * M);
    localparam logic [FILL_W-1:0] W_OUT_F   = FILL_W'(W_OUT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NCH - 1);

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [CHAN_W-1:0] chan_q, chan_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    // Set once the final source word has been appended.
    logic              src_done_q, src_done_d;

    logic              append_en;
    logic [FILL_W-1:0] append_len;
    logic              shift_en;
    logic [W_OUT-1:0]  buf_lo;
    logic [FILL_W-1:0] fill;

    logic [WORD_W-1:0] sel_word;
    logic [WORD_W-1:0] xor_word;
    logic [WORD_W-1:0] load_word;
    logic              have_word;
    logic              out_valid;
    logic              out_last;

    always_comb begin
        sel_word = '0;
        xor_word = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            xor_word = xor_word ^ mem_din[c*WORD_W +: WORD_W];
            if (chan_q == CHAN_W'(c)) begin
                sel_word = mem_din[c*WORD_W +: WORD_W];
            end
        end
        load_word  = mode_q ? xor_word : sel_word;
        append_len = (addr_q == LAST_ADDR) ? LAST_LEN : FULL_LEN;
    end

    // A word is presentable when a full W_OUT is buffered, or the source is exhausted
    // and a partial (zero-padded) remainder is left.
    assign have_word = (fill >= W_OUT_F) || (src_done_q && (fill != '0));

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        chan_d     = chan_q;
        addr_d     = addr_q;
        src_done_d = src_done_q;
        append_en  = 1'b0;
        shift_en   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d     = mode;
                    chan_d     = '0;
                    addr_d     = '0;
                    src_done_d = 1'b0;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                state_d = StLoad;
            end
            StLoad: begin
                append_en = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    addr_d = '0;
                    if (mode_q || (chan_q == LAST_CHAN)) begin
                        src_done_d = 1'b1;
                    end else begin
                        chan_d = chan_q + 1'b1;
                    end
                end else begin
                    addr_d = addr_q + 1'b1;
                end
                state_d = StDrain;
            end
            StDrain: begin
                if (have_word) begin
                    out_valid = 1'b1;
                    out_last  = src_done_q && (fill <= W_OUT_F);
                    if (out_if.dout_ready) begin
                        shift_en = 1'b1;
                        if (out_last) begin
                            state_d = StDone;
                        end
                    end
                end else if (!src_done_q) begin
                    state_d = StFetch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q    <= StIdle;
            mode_q     <= 1'b0;
            chan_q     <= '0;
            addr_q     <= '0;
            src_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            chan_q     <= chan_d;
            addr_q     <= addr_d;
            src_done_q <= src_done_d;
        end
    end

    ct_bit_packer #(
        .IN_W  (WORD_W),
        .OUT_W (W_OUT)
    ) u_packer (
        .clk         (clk),
        .rst_b       (rst_b),
        .append_en   (append_en),
        .append_bits (load_word),
        .append_len  (append_len),
        .shift_en    (shift_en),
        .buf_lo      (buf_lo),
        .fill        (fill)
    );

    assign mem_addr          = (state_q == StIdle) ? '0 : addr_q;
    assign mem_rw            = 1'b0;
    assign out_if.dout       = buf_lo;
    assign out_if.dout_valid = out_valid;
    assign out_if.dout_last  = out_last;
    assign busy              = (state_q == StFetch) || (state_q == StLoad) ||
                               (state_q == StDrain);
    assign done              = (state_q == StDone);

endmodule

// File: tb/tb_ct_stream_out.sv
// Directed bench for ct_stream_out: concat, XOR, backpressure, reset mid-transfer
// and a W_OUT=12 instance with non-byte-aligned output words.
module tb_ct_stream_out;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b;
    logic        start_a, mode_a, start_b, mode_b;
    logic [1:0]  addr_a, addr_b;
    logic        rw_a, rw_b;
    logic [31:0] din_a, din_b;
    logic        busy_a, done_a, busy_b, done_b;

    ct_stream_if #(.W(8))  s_a ();
    ct_stream_if #(.W(12)) s_b ();

    ct_stream_out #(.M(8), .N(5), .DIGIT(2), .NCH(2), .W_OUT(8)) u_dut_a (
        .clk      (clk),
        .rst_b    (rst_b),
        .start    (start_a),
        .mode     (mode_a),
        .mem_addr (addr_a),
        .mem_rw   (rw_a),
        .mem_din  (din_a),
        .out_if   (s_a),
        .busy     (busy_a),
        .done     (done_a)
    );

    ct_stream_out #(.M(8), .N(5), .DIGIT(2), .NCH(2), .W_OUT(12)) u_dut_b (
        .clk      (clk),
        .rst_b    (rst_b),
        .start    (start_b),
        .mode     (mode_b),
        .mem_addr (addr_b),
        .mem_rw   (rw_b),
        .mem_din  (din_b),
        .out_if   (s_b),
        .busy     (busy_b),
        .done     (done_b)
    );

    // Channel memories with a registered read port.
    logic [15:0] a0 [4];
    logic [15:0] a1 [4];
    logic [15:0] b0 [4];
    logic [15:0] b1 [4];
    logic [15:0] rd_a0, rd_a1, rd_b0, rd_b1;

    always @(posedge clk) begin
        rd_a0 <= a0[addr_a];
        rd_a1 <= a1[addr_a];
        rd_b0 <= b0[addr_b];
        rd_b1 <= b1[addr_b];
    end
    assign din_a = {rd_a1, rd_a0};
    assign din_b = {rd_b1, rd_b0};

    int hs_a = 0;
    always @(posedge clk) begin
        if (s_a.dout_valid && s_a.dout_ready) hs_a <= hs_a + 1;
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Receive words first..n-1 from DUT A; last expected on index total-1.
    // With stall set, ready is held low for 3 cycles while dout = 03.
    task automatic expect_a(input string name, input int n, input int total,
                            input logic [7:0] exp_w [10], input bit stall);
        int waitc;
        for (int i = 0; i < n; i++) begin
            waitc = 0;
            while (s_a.dout_valid !== 1'b1 && waitc < 40) begin
                @(negedge clk);
                waitc++;
            end
            check($sformatf("%s valid w%0d", name, i), 32'(s_a.dout_valid), 32'd1);
            check($sformatf("%s dout w%0d", name, i), 32'(s_a.dout), 32'(exp_w[i]));
            check($sformatf("%s last w%0d", name, i), 32'(s_a.dout_last), 32'(i == total - 1));
            if (stall && exp_w[i] == 8'h03) begin
                s_a.dout_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check($sformatf("%s stall dout", name), 32'(s_a.dout), 32'h03);
                    check($sformatf("%s stall valid", name), 32'(s_a.dout_valid), 32'd1);
                    check($sformatf("%s stall last", name), 32'(s_a.dout_last), 32'd0);
                end
                s_a.dout_ready = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_a(input logic m);
        start_a = 1'b1;
        mode_a  = m;
        @(negedge clk);
        start_a = 1'b0;
        mode_a  = ~m;
    endtask

    task automatic check_done_a(input string name);
        check($sformatf("%s done", name), 32'(done_a), 32'd1);
        check($sformatf("%s busy at done", name), 32'(busy_a), 32'd0);
        check($sformatf("%s valid at done", name), 32'(s_a.dout_valid), 32'd0);
        @(negedge clk);
        check($sformatf("%s done pulse", name), 32'(done_a), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "timeout");
    end

    logic [7:0]  seq_cat [10];
    logic [7:0]  seq_xor [10];
    logic [11:0] seq_b   [4];
    int          hs0;
    int          waitc;

    initial begin
        seq_cat = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        seq_xor = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        seq_b   = '{12'h201, 12'h030, 12'h504, 12'h00A};
        a0 = '{16'h0201, 16'h0403, 16'hFF05, 16'h0000};
        a1 = '{16'h2010, 16'h4030, 16'hEE50, 16'h0000};
        b0 = '{16'h0201, 16'h0403, 16'h12A5, 16'h0000};
        b1 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};

        rst_b   = 1'b1;
        start_a = 1'b0;
        mode_a  = 1'b0;
        start_b = 1'b0;
        mode_b  = 1'b0;
        s_a.dout_ready = 1'b1;
        s_b.dout_ready = 1'b1;
        repeat (2) @(negedge clk);

        check("reset valid", 32'(s_a.dout_valid), 32'd0);
        check("reset last", 32'(s_a.dout_last), 32'd0);
        check("reset dout", 32'(s_a.dout), 32'd0);
        check("reset busy", 32'(busy_a), 32'd0);
        check("reset done", 32'(done_a), 32'd0);
        check("reset addr", 32'(addr_a), 32'd0);
        check("reset rw", 32'(rw_a | rw_b), 32'd0);
        check("reset b busy", 32'(busy_b), 32'd0);
        rst_b = 1'b0;
        @(negedge clk);

        // T1: concat, always ready
        hs0 = hs_a;
        pulse_a(1'b0);
        check("T1 busy", 32'(busy_a), 32'd1);
        expect_a("T1", 10, 10, seq_cat, 1'b0);
        check_done_a("T1");
        check("T1 handshakes", 32'(hs_a - hs0), 32'd10);

        // T2: XOR
        hs0 = hs_a;
        pulse_a(1'b1);
        expect_a("T2", 5, 5, seq_xor, 1'b0);
        check_done_a("T2");
        check("T2 handshakes", 32'(hs_a - hs0), 32'd5);

        // T3: backpressure on word 03
        hs0 = hs_a;
        pulse_a(1'b0);
        expect_a("T3", 10, 10, seq_cat, 1'b1);
        check_done_a("T3");
        check("T3 handshakes", 32'(hs_a - hs0), 32'd10);

        // T4: reset mid-DRAIN after the 4th word, with a coincident start
        pulse_a(1'b0);
        expect_a("T4a", 4, 10, seq_cat, 1'b0);
        rst_b   = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        check("T4 rst valid", 32'(s_a.dout_valid), 32'd0);
        check("T4 rst busy", 32'(busy_a), 32'd0);
        check("T4 rst addr", 32'(addr_a), 32'd0);
        rst_b   = 1'b0;
        start_a = 1'b0;
        @(negedge clk);
        check("T4 start in reset ignored", 32'(busy_a), 32'd0);
        pulse_a(1'b0);
        check("T4 busy", 32'(busy_a), 32'd1);
        // A start with mode=1 while busy must not alter the concat transfer.
        pulse_a(1'b1);
        expect_a("T4b", 10, 10, seq_cat, 1'b0);
        check_done_a("T4");

        // T5: W_OUT = 12, XOR with an all-zero second channel
        start_b = 1'b1;
        mode_b  = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        mode_b  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            waitc = 0;
            while (s_b.dout_valid !== 1'b1 && waitc < 40) begin
                @(negedge clk);
                waitc++;
            end
            check($sformatf("T5 valid w%0d", i), 32'(s_b.dout_valid), 32'd1);
            check($sformatf("T5 dout w%0d", i), 32'(s_b.dout), 32'(seq_b[i]));
            check($sformatf("T5 last w%0d", i), 32'(s_b.dout_last), 32'(i == 3));
            @(negedge clk);
        end
        check("T5 done", 32'(done_b), 32'd1);
        check("T5 busy at done", 32'(busy_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
